// File: rtl/jac_to_affine.sv
// Jacobian (X, Y, Z) to affine (X*Z^-2, Y*Z^-3) mod M, given zinv = Z^-1 mod M.
// A single bit-serial interleaved modular multiplier is sequenced through four products.
module jac_to_affine #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] X,
  input  logic [DATA_WIDTH-1:0] Y,
  input  logic [DATA_WIDTH-1:0] zinv,
  input  logic [DATA_WIDTH-1:0] opM,
  input  logic                  in_valid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] x_aff,
  output logic [DATA_WIDTH-1:0] y_aff,
  output logic                  inf,
  output logic                  out_valid
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] x_reg, y_reg, z_reg, m_reg;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, acc_reg, t2_reg, xres_reg;
  logic [IW-1:0]         idx_reg;
  logic [1:0]            op_reg;

  logic [DATA_WIDTH:0]   t_dbl, t_add, m_ext;
  logic [DATA_WIDTH-1:0] t_red1, t_red2, acc_next;
  logic                  accept;

  // One multiplier step: double, reduce, conditionally add a, reduce.
  always_comb begin
    m_ext    = {1'b0, m_reg};
    t_dbl    = {acc_reg, 1'b0};
    t_red1   = (t_dbl >= m_ext) ? DATA_WIDTH'(t_dbl - m_ext) : t_dbl[DATA_WIDTH-1:0];
    t_add    = {1'b0, t_red1} + {1'b0, a_reg};
    t_red2   = (t_add >= m_ext) ? DATA_WIDTH'(t_add - m_ext) : t_add[DATA_WIDTH-1:0];
    acc_next = b_reg[idx_reg] ? t_red2 : t_red1;
  end

  // The DONE exit edge doubles as an IDLE sampling edge so back-to-back
  // requests keep the 4*DATA_WIDTH+6 cycle period.
  assign accept = in_valid && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      m_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      t2_reg    <= '0;
      xres_reg  <= '0;
      idx_reg   <= '0;
      op_reg    <= '0;
      x_aff     <= '0;
      y_aff     <= '0;
      inf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        x_reg <= X;
        y_reg <= Y;
        z_reg <= zinv;
        m_reg <= opM;
      end
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (accept) state <= S_LOAD;
        end
        S_LOAD: begin
          a_reg   <= z_reg;
          b_reg   <= z_reg;
          acc_reg <= '0;
          idx_reg <= IDX_TOP;
          op_reg  <= 2'd0;
          state   <= S_MUL;
        end
        S_MUL: begin
          acc_reg <= acc_next;
          if (idx_reg == '0) state <= S_WB;
          else idx_reg <= idx_reg - 1'b1;
        end
        S_WB: begin
          acc_reg <= '0;
          idx_reg <= IDX_TOP;
          op_reg  <= op_reg + 2'd1;
          state   <= S_MUL;
          case (op_reg)
            2'd0: begin
              t2_reg <= acc_reg;
              a_reg  <= x_reg;
              b_reg  <= acc_reg;
            end
            2'd1: begin
              xres_reg <= acc_reg;
              a_reg    <= t2_reg;
              b_reg    <= z_reg;
            end
            2'd2: begin
              a_reg <= y_reg;
              b_reg <= acc_reg;
            end
            default: begin
              x_aff     <= xres_reg;
              y_aff     <= acc_reg;
              inf       <= (z_reg == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          out_valid <= 1'b0;
          state     <= accept ? S_LOAD : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
